// File: rtl/aec_pkg.sv
// Shared constants and state encoding for the arithmetic-expression arbiter.
package aec_pkg;

  localparam logic [7:0] AsciiEq     = 8'h3D;
  localparam logic [7:0] AsciiLParen = 8'h28;
  localparam logic [7:0] AsciiRParen = 8'h29;
  localparam logic [7:0] AsciiMul    = 8'h2A;
  localparam logic [7:0] AsciiAdd    = 8'h2B;
  localparam logic [7:0] AsciiSub    = 8'h2D;

  localparam int unsigned MaxLenDefault  = 16;
  localparam int unsigned TimeoutDefault = 63;
  localparam int unsigned WaitCntW       = 6;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StWait,
    StGap
  } aec_state_e;

endpackage

// File: rtl/aec_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping, as a one-hot grant.
module aec_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [PtrW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PtrW'((32'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aec_arbiter.sv
// Arbitrates NREQ expression streams onto one evaluator and routes its result back
// to the granted requester, with underrun, overflow and timeout recovery.
module aec_arbiter
  import aec_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAXLEN  = MaxLenDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_char,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   resp_valid,
  output logic [6:0]        resp_result,
  output logic              resp_err,
  output logic              eval_ready,
  output logic [7:0]        eval_ascii,
  output logic              eval_clr,
  input  logic              eval_valid,
  input  logic [6:0]        eval_result
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAXLEN + 1);

  aec_state_e          state_q, state_d;
  // Holds the current grant and doubles as the round-robin pointer.
  logic [PtrW-1:0]     gnt_q, gnt_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WaitCntW-1:0] wait_q, wait_d;
  logic                err_q, err_d;
  logic [7:0]          ascii_q, ascii_d;
  logic                ready_q, ready_d;
  logic                clr_q, clr_d;
  logic [NREQ-1:0]     rv_q, rv_d;
  logic [6:0]          res_q, res_d;
  logic                rerr_q, rerr_d;

  logic [NREQ-1:0]     pick_gnt;
  logic                pick_valid;
  logic [PtrW-1:0]     pick_idx;
  logic                cur_valid;
  logic [7:0]          cur_char;

  aec_rr_pick #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (gnt_q),
    .grant (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = PtrW'(i);
    end
  end

  assign cur_valid = req_valid[gnt_q];
  assign cur_char  = req_char[{gnt_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ascii_d = 8'h00;
    ready_d = 1'b0;
    clr_d   = 1'b0;
    rv_d    = '0;
    res_d   = res_q;
    rerr_d  = rerr_q;
    req_ack = '0;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = StStream;
        end
      end

      StStream: begin
        ready_d = (cnt_q == '0);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(MAXLEN - 1)) begin
          // Length limit: terminate on the requester's behalf without consuming.
          ascii_d = AsciiEq;
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = StWait;
        end else if (!cur_valid) begin
          // Underrun: the evaluator must never see a bubble, so close it now.
          ascii_d = AsciiEq;
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = StWait;
        end else begin
          req_ack[gnt_q] = 1'b1;
          ascii_d        = cur_char;
          if (cur_char == AsciiEq) begin
            wait_d  = '0;
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (eval_valid) begin
          rv_d[gnt_q] = 1'b1;
          res_d       = eval_result;
          rerr_d      = err_q;
          state_d     = StGap;
        end else if (wait_q == WaitCntW'(TIMEOUT - 1)) begin
          rv_d[gnt_q] = 1'b1;
          res_d       = '0;
          rerr_d      = 1'b1;
          clr_d       = 1'b1;
          state_d     = StGap;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StGap: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        wait_d  = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= PtrW'(NREQ - 1);
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ascii_q <= 8'h00;
      ready_q <= 1'b0;
      clr_q   <= 1'b0;
      rv_q    <= '0;
      res_q   <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ascii_q <= ascii_d;
      ready_q <= ready_d;
      clr_q   <= clr_d;
      rv_q    <= rv_d;
      res_q   <= res_d;
      rerr_q  <= rerr_d;
    end
  end

  assign resp_valid  = rv_q;
  assign resp_result = res_q;
  assign resp_err    = rerr_q;
  assign eval_ready  = ready_q;
  assign eval_ascii  = ascii_q;
  assign eval_clr    = clr_q;

endmodule
